// File: rtl/daq_pkg.sv
// Shared types, constants and helpers for the DAQ read-clock burst generator.
package daq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  // Widest channel mask the priority encoder handles.
  localparam int MAX_CH = 32;

  // Index of the lowest set bit of mask at or above 'from', or -1 if none.
  function automatic int lowest_set_from(input logic [MAX_CH-1:0] mask, input int from);
    int idx;
    idx = -1;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/daq_phase_timer.sv
// Loadable down-counter timing one LOW or HIGH phase of the read clock.
// Loading N (N>=1) makes expired_o rise on the N-th cycle after the load edge.
module daq_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: reload on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i - 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/daq_rdclk_burst.sv
// Read-clock generator for the DAQ ADC read path: programmable high/low phases,
// bursts sequenced over the enabled channels, or free-running until stopped.
module daq_rdclk_burst
  import daq_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 16,
  parameter int NCH     = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [CNT_W-1:0]   high_cnt_i,
  input  logic [CNT_W-1:0]   low_cnt_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic [NCH-1:0]     ch_mask_i,
  input  logic               free_run_i,
  input  logic               en_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               clk_o,
  output logic               clk_en_o,
  output logic [NCH-1:0]     ch_sel_o,
  output logic               rd_strobe_o,
  output logic [BURST_W-1:0] pulse_cnt_o
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic [CNT_W-1:0]   low_q, low_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic               free_q, free_d;
  logic               stop_q, stop_d;
  logic [IDX_W-1:0]   ch_idx_q, ch_idx_d;
  logic [NCH-1:0]     ch_sel_q, ch_sel_d;
  logic [BURST_W-1:0] pulse_cnt_q, pulse_cnt_d;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_expired;

  logic [CNT_W-1:0]   high_in, low_in;
  logic [MAX_CH-1:0]  mask_ext_in, mask_ext_q;
  logic [BURST_W-1:0] pulse_inc;
  logic               stop_now;

  // A programmed length of zero behaves as one cycle.
  assign high_in     = (high_cnt_i == '0) ? CNT_ONE : high_cnt_i;
  assign low_in      = (low_cnt_i == '0) ? CNT_ONE : low_cnt_i;
  assign mask_ext_in = MAX_CH'(ch_mask_i);
  assign mask_ext_q  = MAX_CH'(mask_q);
  assign pulse_inc   = pulse_cnt_q + 1'b1;
  assign stop_now    = stop_i | stop_q;

  daq_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // Next-state logic: phase sequencing, channel stepping and stop handling.
  always_comb begin
    int nxt;
    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    state_d     = state_q;
    high_d      = high_q;
    low_d       = low_q;
    burst_d     = burst_q;
    mask_d      = mask_q;
    free_d      = free_q;
    stop_d      = stop_q;
    ch_idx_d    = ch_idx_q;
    ch_sel_d    = ch_sel_q;
    pulse_cnt_d = pulse_cnt_q;
    tmr_load    = 1'b0;
    tmr_val     = low_q;
    nxt         = 0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          high_d      = high_in;
          low_d       = low_in;
          burst_d     = burst_len_i;
          mask_d      = ch_mask_i;
          free_d      = free_run_i;
          stop_d      = 1'b0;
          pulse_cnt_d = '0;
          if (!free_run_i && ((ch_mask_i == '0) || (burst_len_i == '0))) begin
            state_d = DONE;
          end else begin
            nxt      = free_run_i ? 0 : lowest_set_from(mask_ext_in, 0);
            state_d  = LOW;
            tmr_load = 1'b1;
            tmr_val  = low_in;
            ch_idx_d = IDX_W'(nxt);
            for (int i = 0; i < NCH; i++) ch_sel_d[i] = (i == nxt);
          end
        end
      end

      LOW: begin
        if (stop_now) begin
          state_d  = DONE;
          ch_sel_d = '0;
        end else if (tmr_expired) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
          tmr_val  = high_q;
        end
      end

      HIGH: begin
        // A stop seen mid-pulse is held so the high phase always runs to full length.
        stop_d = stop_now;
        if (tmr_expired) begin
          if (stop_now) begin
            state_d     = DONE;
            ch_sel_d    = '0;
            pulse_cnt_d = pulse_inc;
          end else if (!free_q && (pulse_inc == burst_q)) begin
            nxt = lowest_set_from(mask_ext_q, int'(ch_idx_q) + 1);
            if (nxt < 0) begin
              state_d     = DONE;
              ch_sel_d    = '0;
              pulse_cnt_d = pulse_inc;
            end else begin
              state_d     = LOW;
              tmr_load    = 1'b1;
              tmr_val     = low_q;
              pulse_cnt_d = '0;
              ch_idx_d    = IDX_W'(nxt);
              for (int i = 0; i < NCH; i++) ch_sel_d[i] = (i == nxt);
            end
          end else begin
            state_d     = LOW;
            tmr_load    = 1'b1;
            tmr_val     = low_q;
            pulse_cnt_d = pulse_inc;
          end
        end
      end

      DONE: begin
        state_d     = IDLE;
        stop_d      = 1'b0;
        ch_sel_d    = '0;
        pulse_cnt_d = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and configuration registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_ni) begin
      state_q     <= IDLE;
      high_q      <= CNT_ONE;
      low_q       <= CNT_ONE;
      burst_q     <= '0;
      mask_q      <= '0;
      free_q      <= 1'b0;
      stop_q      <= 1'b0;
      ch_idx_q    <= '0;
      ch_sel_q    <= '0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      high_q      <= high_d;
      low_q       <= low_d;
      burst_q     <= burst_d;
      mask_q      <= mask_d;
      free_q      <= free_d;
      stop_q      <= stop_d;
      ch_idx_q    <= ch_idx_d;
      ch_sel_q    <= ch_sel_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign busy_o      = (state_q == LOW) || (state_q == HIGH);
  assign done_o      = (state_q == DONE);
  assign clk_o       = (state_q == HIGH) ? HI : LO;
  assign rd_strobe_o = (state_q == HIGH) && tmr_expired;
  assign ch_sel_o    = ch_sel_q;
  assign pulse_cnt_o = pulse_cnt_q;
  // Legacy gated clock: held high while gating is off.
  assign clk_en_o    = en_i ? clk_o : HI;

endmodule

// File: tb/tb_daq_rdclk_burst.sv
// Self-checking bench: directed and randomized sequences compared cycle by cycle
// against an expected-waveform model built from the phase/burst/stop rules.
module tb_daq_rdclk_burst;

  logic        clk_i;
  logic        reset_ni;
  logic        start_i;
  logic        stop_i;
  logic [7:0]  high_cnt_i;
  logic [7:0]  low_cnt_i;
  logic [15:0] burst_len_i;
  logic [3:0]  ch_mask_i;
  logic        free_run_i;
  logic        en_i;
  logic        busy_o;
  logic        done_o;
  logic        clk_o;
  logic        clk_en_o;
  logic [3:0]  ch_sel_o;
  logic        rd_strobe_o;
  logic [15:0] pulse_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  // ph: 0 = low phase, 1 = high phase, 2 = done cycle, 3 = idle
  typedef struct {
    int          ph;
    logic        clk;
    logic        busy;
    logic        done;
    logic        strobe;
    logic [3:0]  ch;
    logic [15:0] pc;
  } rec_t;

  rec_t exp_q[$];

  daq_rdclk_burst #(.CNT_W(8), .BURST_W(16), .NCH(4)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .high_cnt_i  (high_cnt_i),
    .low_cnt_i   (low_cnt_i),
    .burst_len_i (burst_len_i),
    .ch_mask_i   (ch_mask_i),
    .free_run_i  (free_run_i),
    .en_i        (en_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .clk_o       (clk_o),
    .clk_en_o    (clk_en_o),
    .ch_sel_o    (ch_sel_o),
    .rd_strobe_o (rd_strobe_o),
    .pulse_cnt_o (pulse_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic rec_t mk(input int ph, input logic [3:0] ch, input logic [15:0] pc,
                              input logic strobe);
    rec_t r;
    r.ph     = ph;
    r.clk    = (ph == 1);
    r.busy   = (ph < 2);
    r.done   = (ph == 2);
    r.strobe = strobe;
    r.ch     = ch;
    r.pc     = pc;
    return r;
  endfunction

  // Expected per-cycle outputs, starting with the cycle after the start edge.
  task automatic build_trace(input int h, input int l, input int b, input int m,
                             input bit fr, input int stop_at);
    int hh, ll, npulse, cut, j;
    int chans[$];
    logic [15:0] end_pc;
    exp_q.delete();
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    if (!fr && (m == 0 || b == 0)) begin
      exp_q.push_back(mk(2, 4'b0000, 16'd0, 1'b0));
      exp_q.push_back(mk(3, 4'b0000, 16'd0, 1'b0));
      return;
    end
    if (fr) chans.push_back(0);
    else for (int c = 0; c < 4; c++) if (m[c]) chans.push_back(c);
    npulse = fr ? (stop_at / (hh + ll) + 2) : b;
    foreach (chans[ci]) begin
      for (int p = 0; p < npulse; p++) begin
        for (int k = 0; k < ll; k++) exp_q.push_back(mk(0, 4'(1 << chans[ci]), 16'(p), 1'b0));
        for (int k = 0; k < hh; k++)
          exp_q.push_back(mk(1, 4'(1 << chans[ci]), 16'(p), (k == hh - 1)));
      end
    end
    end_pc = 16'(b);
    if (stop_at >= 0 && stop_at < exp_q.size()) begin
      if (exp_q[stop_at].ph == 0) begin
        end_pc = exp_q[stop_at].pc;
        cut    = stop_at + 1;
      end else begin
        j = stop_at;
        while (j + 1 < exp_q.size() && exp_q[j + 1].ph == 1) j++;
        end_pc = exp_q[j].pc + 16'd1;
        cut    = j + 1;
      end
      while (exp_q.size() > cut) void'(exp_q.pop_back());
    end
    exp_q.push_back(mk(2, 4'b0000, end_pc, 1'b0));
    exp_q.push_back(mk(3, 4'b0000, 16'd0, 1'b0));
  endtask

  // Issue a start, then compare every cycle; stop_i is raised during cycle stop_at.
  // en_mode: 0/1 hold en_i, 2 randomizes it. Extra starts while busy must be ignored.
  task automatic run_seq(input string name, input int h, input int l, input int b,
                         input int m, input bit fr, input int stop_at, input int en_mode);
    string tg;
    build_trace(h, l, b, m, fr, stop_at);
    high_cnt_i  = 8'(h);
    low_cnt_i   = 8'(l);
    burst_len_i = 16'(b);
    ch_mask_i   = 4'(m);
    free_run_i  = fr;
    stop_i      = 1'b0;
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    foreach (exp_q[t]) begin
      tg = $sformatf("%s[%0d]", name, t);
      check({tg, ".clk"},    32'(clk_o),       32'(exp_q[t].clk));
      check({tg, ".busy"},   32'(busy_o),      32'(exp_q[t].busy));
      check({tg, ".done"},   32'(done_o),      32'(exp_q[t].done));
      check({tg, ".ch"},     32'(ch_sel_o),    32'(exp_q[t].ch));
      check({tg, ".strobe"}, 32'(rd_strobe_o), 32'(exp_q[t].strobe));
      check({tg, ".pcnt"},   32'(pulse_cnt_o), 32'(exp_q[t].pc));
      check({tg, ".clk_en"}, 32'(clk_en_o),    32'(en_i ? exp_q[t].clk : 1'b1));
      stop_i = (t == stop_at);
      en_i   = (en_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(en_mode);
      if (exp_q[t].busy && $urandom_range(0, 3) == 0) begin
        start_i     = 1'b1;
        high_cnt_i  = 8'($urandom_range(0, 5));
        low_cnt_i   = 8'($urandom_range(0, 5));
        burst_len_i = 16'($urandom_range(0, 5));
        ch_mask_i   = 4'($urandom_range(0, 15));
        free_run_i  = 1'($urandom_range(0, 1));
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, ".clk"},    32'(clk_o),       32'd0);
    check({name, ".busy"},   32'(busy_o),      32'd0);
    check({name, ".done"},   32'(done_o),      32'd0);
    check({name, ".ch"},     32'(ch_sel_o),    32'd0);
    check({name, ".strobe"}, 32'(rd_strobe_o), 32'd0);
    check({name, ".pcnt"},   32'(pulse_cnt_o), 32'd0);
    check({name, ".clk_en"}, 32'(clk_en_o),    32'(en_i ? 1'b0 : 1'b1));
  endtask

  initial begin
    int h, l, b, m, sa, len;
    bit fr;
    reset_ni    = 1'b0;
    start_i     = 1'b0;
    stop_i      = 1'b0;
    high_cnt_i  = '0;
    low_cnt_i   = '0;
    burst_len_i = '0;
    ch_mask_i   = '0;
    free_run_i  = 1'b0;
    en_i        = 1'b0;
    repeat (2) @(negedge clk_i);
    check_idle("reset");
    reset_ni = 1'b1;
    @(negedge clk_i);

    // Single channel, 4 pulses of 2 high / 3 low.
    run_seq("single", 2, 3, 4, 4'b0001, 1'b0, -1, 1);
    // Two channels, two pulses each.
    run_seq("twoch", 1, 1, 2, 4'b1010, 1'b0, -1, 2);
    // Free run with zero lengths (1/1 toggle), stop in a high cycle.
    run_seq("free11", 0, 0, 0, 4'b0000, 1'b1, 5, 1);
    // Free run with a 3-cycle high, stop in its middle cycle.
    run_seq("freemid", 3, 0, 0, 4'b0000, 1'b1, 2, 1);
    // Free run, stop during a low phase.
    run_seq("freelow", 1, 2, 0, 4'b0000, 1'b1, 6, 2);
    // Stop on the final high cycle of the last burst: single done.
    run_seq("stoplast", 1, 1, 2, 4'b0001, 1'b0, 3, 1);
    // Empty mask and zero burst length: immediate done, no clock.
    run_seq("mask0", 2, 2, 3, 4'b0000, 1'b0, -1, 1);
    run_seq("burst0", 2, 2, 0, 4'b0101, 1'b0, -1, 1);
    // Gating off for a whole burst.
    run_seq("gateoff", 2, 1, 2, 4'b1001, 1'b0, -1, 0);

    // Reset in the middle of a burst aborts it with no done.
    high_cnt_i  = 8'd2;
    low_cnt_i   = 8'd2;
    burst_len_i = 16'd3;
    ch_mask_i   = 4'b0110;
    free_run_i  = 1'b0;
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("midrst.busy_before", 32'(busy_o), 32'd1);
    reset_ni = 1'b0;
    en_i     = 1'b0;
    @(negedge clk_i);
    check_idle("midrst");
    reset_ni = 1'b1;
    @(negedge clk_i);
    check_idle("midrst_after");
    run_seq("afterrst", 1, 2, 1, 4'b0100, 1'b0, -1, 2);

    // Randomized configurations.
    for (int it = 0; it < 30; it++) begin
      h   = $urandom_range(0, 3);
      l   = $urandom_range(0, 3);
      b   = $urandom_range(0, 3);
      m   = $urandom_range(0, 15);
      fr  = ($urandom_range(0, 4) == 0);
      len = 4 * ((b == 0) ? 1 : b) * (4 + 4) + 4;
      if (fr) sa = $urandom_range(0, 20);
      else sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len)) : -1;
      run_seq($sformatf("rnd%0d", it), h, l, b, m, fr, sa, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
